// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : opcode encodings and FSM state type shared by the mc_alu slice
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] c_OP_NOT   = 4'd0;
    localparam logic [3:0] c_OP_AND   = 4'd1;
    localparam logic [3:0] c_OP_OR    = 4'd2;
    localparam logic [3:0] c_OP_XOR   = 4'd3;
    localparam logic [3:0] c_OP_XNOR  = 4'd4;
    localparam logic [3:0] c_OP_NOR   = 4'd5;
    localparam logic [3:0] c_OP_NAND  = 4'd6;
    localparam logic [3:0] c_OP_SLL   = 4'd7;
    localparam logic [3:0] c_OP_SRL   = 4'd8;
    localparam logic [3:0] c_OP_ADD   = 4'd9;
    localparam logic [3:0] c_OP_SUB   = 4'd10;
    localparam logic [3:0] c_OP_MUL   = 4'd11;
    localparam logic [3:0] c_OP_DIV   = 4'd12;
    localparam logic [3:0] c_OP_PASS  = 4'd13;
    localparam logic [3:0] c_OP_PASSB = 4'd14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/iter_muldiv.sv
// ============================================================================
// iter_muldiv : shared one-bit-per-clock shift-add multiplier / restoring divider
// Rev 1.0
// ============================================================================
`default_nettype none

module iter_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             isDiv,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_op;
    logic             r_isDiv;
    logic             r_busy;
    logic [SHW-1:0]   r_count;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;
    logic [WIDTH-1:0] w_nextHi;
    logic [WIDTH-1:0] w_nextLo;

    // MUL: hi accumulates, lo holds the multiplier and shifts product bits in.
    // DIV: hi is the partial remainder, lo shifts dividend out and quotient in.
    always_comb begin
        w_addend  = r_lo[0] ? r_op : '0;
        w_sum     = {1'b0, r_hi} + {1'b0, w_addend};
        w_shifted = {r_hi, r_lo[WIDTH-1]};
        w_diff    = w_shifted - {1'b0, r_op};
        w_fits    = ~w_diff[WIDTH];
        if (r_isDiv) begin
            w_nextHi = w_fits ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
            w_nextLo = {r_lo[WIDTH-2:0], w_fits};
        end else begin
            w_nextHi = w_sum[WIDTH:1];
            w_nextLo = {w_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    // Outputs are the post-step values so the final step's result is
    // available in the same cycle done is high.
    assign done = r_busy && (r_count == SHW'(WIDTH - 1));
    assign lo   = w_nextLo;
    assign hi   = w_nextHi;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_op    <= '0;
            r_isDiv <= 1'b0;
            r_busy  <= 1'b0;
            r_count <= '0;
        end else if (start) begin
            r_hi    <= '0;
            r_lo    <= a;
            r_op    <= b;
            r_isDiv <= isDiv;
            r_busy  <= 1'b1;
            r_count <= '0;
        end else if (r_busy) begin
            r_hi    <= w_nextHi;
            r_lo    <= w_nextLo;
            r_count <= r_count + 1'b1;
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mc_alu.sv
// ============================================================================
// mc_alu : multi-cycle 15-op ALU with valid/ready handshakes and registered outputs
// Rev 1.0
// ============================================================================
`default_nettype none

module mc_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opSel,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] resultExt,
    output logic             carryFlag,
    output logic             signFlag,
    output logic             zeroFlag,
    output logic             divZero
);

    localparam int SHW = $clog2(WIDTH);

    state_t r_state;
    state_t w_nextState;

    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_resultExt;
    logic             r_carry;
    logic             r_sign;
    logic             r_zero;
    logic             r_divZero;

    logic [SHW-1:0]   w_shAmt;
    logic [WIDTH:0]   w_sll;
    logic [WIDTH:0]   w_srl;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_ext;
    logic             w_carry;
    logic             w_divZero;
    logic             w_iterative;
    logic             w_start;
    logic             w_mdDone;
    logic [WIDTH-1:0] w_mdLo;
    logic [WIDTH-1:0] w_mdHi;

    assign w_shAmt     = b[SHW-1:0];
    assign w_iterative = (opSel == c_OP_MUL) || ((opSel == c_OP_DIV) && (b != '0));

    // The extra bit on each shift catches the last bit shifted out, which is
    // zero for a shift amount of zero.
    always_comb begin
        w_sll     = {1'b0, a} << w_shAmt;
        w_srl     = {a, 1'b0} >> w_shAmt;
        w_add     = {1'b0, a} + {1'b0, b};
        w_sub     = {1'b0, a} - {1'b0, b};
        w_res     = a;
        w_ext     = '0;
        w_carry   = 1'b0;
        w_divZero = 1'b0;
        case (opSel)
            c_OP_NOT:   w_res = ~a;
            c_OP_AND:   w_res = a & b;
            c_OP_OR:    w_res = a | b;
            c_OP_XOR:   w_res = a ^ b;
            c_OP_XNOR:  w_res = ~(a ^ b);
            c_OP_NOR:   w_res = ~(a | b);
            c_OP_NAND:  w_res = ~(a & b);
            c_OP_SLL:   {w_carry, w_res} = w_sll;
            c_OP_SRL:   {w_res, w_carry} = w_srl;
            c_OP_ADD:   {w_carry, w_res} = w_add;
            c_OP_SUB:   {w_carry, w_res} = w_sub;
            c_OP_DIV: begin
                w_res     = '1;
                w_ext     = a;
                w_divZero = 1'b1;
            end
            c_OP_PASSB: w_res = b;
            default:    w_res = a;
        endcase
    end

    always_comb begin
        w_nextState = r_state;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                if (inValid) begin
                    if (w_iterative) begin
                        w_nextState = BUSY;
                        w_start     = 1'b1;
                    end else begin
                        w_nextState = DONE;
                    end
                end
            end
            BUSY: if (w_mdDone) w_nextState = DONE;
            DONE: if (outReady) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .isDiv (opSel == c_OP_DIV),
        .a     (a),
        .b     (b),
        .done  (w_mdDone),
        .lo    (w_mdLo),
        .hi    (w_mdHi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result    <= '0;
            r_resultExt <= '0;
            r_carry     <= 1'b0;
            r_sign      <= 1'b0;
            r_zero      <= 1'b0;
            r_divZero   <= 1'b0;
        end else if ((r_state == IDLE) && inValid && !w_iterative) begin
            r_result    <= w_res;
            r_resultExt <= w_ext;
            r_carry     <= w_carry;
            r_sign      <= w_res[WIDTH-1];
            r_zero      <= (w_res == '0);
            r_divZero   <= w_divZero;
        end else if ((r_state == BUSY) && w_mdDone) begin
            r_result    <= w_mdLo;
            r_resultExt <= w_mdHi;
            r_carry     <= 1'b0;
            r_sign      <= w_mdLo[WIDTH-1];
            r_zero      <= (w_mdLo == '0);
            r_divZero   <= 1'b0;
        end
    end

    assign inReady   = (r_state == IDLE);
    assign outValid  = (r_state == DONE);
    assign result    = r_result;
    assign resultExt = r_resultExt;
    assign carryFlag = r_carry;
    assign signFlag  = r_sign;
    assign zeroFlag  = r_zero;
    assign divZero   = r_divZero;

endmodule

`default_nettype wire
